// File: rtl/cv32e41s_rvfi_data_sched.sv
// RVFI data-memory scheduler: queues write-buffer transactions and releases each
// retiring LSU instruction's 1- or 2-beat group with write data in memory byte order.
module cv32e41s_rvfi_data_sched #(
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         trans_valid_i,
  input  logic [31:0]                  trans_addr_i,
  input  logic                         trans_we_i,
  input  logic [3:0]                   trans_be_i,
  input  logic [31:0]                  trans_wdata_i,
  input  logic                         trans_last_i,
  input  logic                         retire_i,
  input  logic                         flush_i,
  output logic                         out_valid_o,
  output logic [1:0]                   out_cnt_o,
  output logic [63:0]                  out_addr_o,
  output logic [1:0]                   out_we_o,
  output logic [7:0]                   out_be_o,
  output logic [63:0]                  out_wdata_o,
  output logic [$clog2(DEPTH+1)-1:0]   level_o,
  output logic                         full_o,
  output logic                         empty_o,
  output logic                         err_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH+1);

  typedef struct packed {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        last;
  } entry_t;

  entry_t        mem [DEPTH];
  entry_t        head0, head1;
  logic [AW-1:0] wptr, rptr, rptr1;
  logic [LW-1:0] level, level_next;
  logic [1:0]    pop_cnt;
  logic          full, push, ovf, ret_err;

  // Rotate right by the byte offset: memory byte i holds LSU lane byte i+offset.
  function automatic logic [31:0] align_wdata(input logic [31:0] wdata, input logic [1:0] off);
    logic [63:0] dbl;
    dbl = {wdata, wdata} >> {off, 3'b000};
    return dbl[31:0];
  endfunction

  // NOTE: every signal assigned in always_comb gets a default first so no latch is inferred.
  always_comb begin
    rptr1   = rptr + AW'(1);
    head0   = mem[rptr];
    head1   = mem[rptr1];
    pop_cnt = 2'd0;
    ret_err = 1'b0;
    if (retire_i) begin
      if (level == '0) begin
        ret_err = 1'b1;
      end else if (head0.last) begin
        pop_cnt = 2'd1;
      end else if (level >= LW'(2)) begin
        pop_cnt = 2'd2;
        ret_err = !head1.last;
      end else begin
        ret_err = 1'b1;
      end
    end
    // Full is judged before this cycle's pop, so a pop never makes room for a same-cycle push.
    full       = (level == LW'(DEPTH));
    push       = trans_valid_i && !full && !flush_i;
    ovf        = trans_valid_i && full && !flush_i;
    level_next = flush_i ? '0 : level + LW'(push) - LW'(pop_cnt);
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr        <= '0;
      rptr        <= '0;
      level       <= '0;
      err_o       <= 1'b0;
      out_valid_o <= 1'b0;
      out_cnt_o   <= 2'd0;
      out_addr_o  <= '0;
      out_we_o    <= '0;
      out_be_o    <= '0;
      out_wdata_o <= '0;
    end else begin
      wptr        <= flush_i ? '0 : wptr + AW'(push);
      rptr        <= flush_i ? '0 : rptr + AW'(pop_cnt);
      level       <= level_next;
      err_o       <= err_o | ovf | ret_err;
      out_valid_o <= (pop_cnt != 2'd0);
      out_cnt_o   <= pop_cnt;
      out_addr_o  <= '0;
      out_we_o    <= '0;
      out_be_o    <= '0;
      out_wdata_o <= '0;
      if (pop_cnt != 2'd0) begin
        out_addr_o[31:0]  <= head0.addr;
        out_we_o[0]       <= head0.we;
        out_be_o[3:0]     <= head0.be;
        out_wdata_o[31:0] <= align_wdata(head0.wdata, head0.addr[1:0]);
      end
      if (pop_cnt == 2'd2) begin
        out_addr_o[63:32]  <= head1.addr;
        out_we_o[1]        <= head1.we;
        out_be_o[7:4]      <= head1.be;
        out_wdata_o[63:32] <= align_wdata(head1.wdata, head1.addr[1:0]);
      end
    end
  end

  // NOTE: the storage array is not reset; only pointers and level define which entries are live.
  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= {trans_addr_i, trans_we_i, trans_be_i, trans_wdata_i, trans_last_i};
  end

  assign level_o = level;
  assign full_o  = full;
  assign empty_o = (level == '0);

endmodule

// File: tb/tb_cv32e41s_rvfi_data_sched.sv
// Self-checking bench: directed scenarios plus randomized traffic compared to a queue-based model.
module tb_cv32e41s_rvfi_data_sched;

  localparam int DEPTH = 4;
  localparam int LW    = $clog2(DEPTH+1);

  logic          clk = 1'b0;
  logic          rst;
  logic          trans_valid_i, trans_we_i, trans_last_i, retire_i, flush_i;
  logic [31:0]   trans_addr_i, trans_wdata_i;
  logic [3:0]    trans_be_i;
  logic          out_valid_o, full_o, empty_o, err_o;
  logic [1:0]    out_cnt_o, out_we_o;
  logic [63:0]   out_addr_o, out_wdata_o;
  logic [7:0]    out_be_o;
  logic [LW-1:0] level_o;

  always #5 clk = ~clk;

  cv32e41s_rvfi_data_sched #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .trans_valid_i(trans_valid_i), .trans_addr_i(trans_addr_i), .trans_we_i(trans_we_i),
    .trans_be_i(trans_be_i), .trans_wdata_i(trans_wdata_i), .trans_last_i(trans_last_i),
    .retire_i(retire_i), .flush_i(flush_i),
    .out_valid_o(out_valid_o), .out_cnt_o(out_cnt_o), .out_addr_o(out_addr_o),
    .out_we_o(out_we_o), .out_be_o(out_be_o), .out_wdata_o(out_wdata_o),
    .level_o(level_o), .full_o(full_o), .empty_o(empty_o), .err_o(err_o)
  );

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        last;
  } txn_t;

  txn_t        q[$];
  int          checks = 0;
  int          errors = 0;
  logic        m_valid, m_err;
  logic [1:0]  m_cnt, m_we;
  logic [63:0] m_addr, m_wdata;
  logic [7:0]  m_be;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Memory byte i of a beat is LSU lane byte (i + offset) mod 4.
  function automatic logic [31:0] mem_order(input logic [31:0] w, input logic [1:0] off);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = w[8*((i + int'(off)) % 4) +: 8];
    return r;
  endfunction

  task automatic model_reset();
    q.delete();
    m_valid = 0; m_err = 0; m_cnt = 0; m_we = 0; m_addr = 0; m_wdata = 0; m_be = 0;
  endtask

  task automatic model_step();
    int n, pop;
    txn_t t;
    n = q.size();
    pop = 0;
    m_valid = 0; m_cnt = 0; m_we = 0; m_addr = 0; m_wdata = 0; m_be = 0;
    if (retire_i) begin
      if (n == 0) m_err = 1;
      else if (q[0].last) pop = 1;
      else if (n >= 2) begin pop = 2; if (!q[1].last) m_err = 1; end
      else m_err = 1;
      for (int b = 0; b < pop; b++) begin
        t = q.pop_front();
        m_addr[32*b +: 32]  = t.addr;
        m_we[b]             = t.we;
        m_be[4*b +: 4]      = t.be;
        m_wdata[32*b +: 32] = mem_order(t.wdata, t.addr[1:0]);
      end
      m_valid = (pop > 0);
      m_cnt   = 2'(pop);
    end
    if (flush_i) q.delete();
    else if (trans_valid_i) begin
      if (n == DEPTH) m_err = 1;
      else begin
        t.addr = trans_addr_i; t.we = trans_we_i; t.be = trans_be_i;
        t.wdata = trans_wdata_i; t.last = trans_last_i;
        q.push_back(t);
      end
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".valid"}, 64'(out_valid_o), 64'(m_valid));
    check({tag, ".cnt"},   64'(out_cnt_o),   64'(m_cnt));
    check({tag, ".addr"},  out_addr_o,       m_addr);
    check({tag, ".we"},    64'(out_we_o),    64'(m_we));
    check({tag, ".be"},    64'(out_be_o),    64'(m_be));
    check({tag, ".wdata"}, out_wdata_o,      m_wdata);
    check({tag, ".level"}, 64'(level_o),     64'(q.size()));
    check({tag, ".full"},  64'(full_o),      64'(q.size() == DEPTH));
    check({tag, ".empty"}, 64'(empty_o),     64'(q.size() == 0));
    check({tag, ".err"},   64'(err_o),       64'(m_err));
  endtask

  task automatic idle_inputs();
    trans_valid_i = 0; trans_addr_i = 0; trans_we_i = 0; trans_be_i = 0;
    trans_wdata_i = 0; trans_last_i = 0; retire_i = 0; flush_i = 0;
  endtask

  // One clock: inputs already driven; advance, update model, check, then idle inputs.
  task automatic cycle(input string tag);
    @(posedge clk);
    model_step();
    #1;
    check_all(tag);
    idle_inputs();
  endtask

  task automatic push(input logic [31:0] a, input logic [3:0] be, input logic [31:0] wd,
                      input logic last, input logic ret, input logic fl, input string tag);
    trans_valid_i = 1; trans_addr_i = a; trans_we_i = 1; trans_be_i = be;
    trans_wdata_i = wd; trans_last_i = last; retire_i = ret; flush_i = fl;
    cycle(tag);
  endtask

  task automatic retire(input string tag);
    retire_i = 1;
    cycle(tag);
  endtask

  task automatic do_reset();
    rst = 1;
    #1;
    model_reset();
    check_all("rst");
    #2 rst = 0;
  endtask

  initial begin
    idle_inputs();
    rst = 1;
    model_reset();
    #3;
    check_all("por");
    @(posedge clk); #2 rst = 0;

    // Aligned-offset write, released two cycles later
    push(32'h1002, 4'hC, 32'h0000_BEEF, 1, 0, 0, "t1.push");
    cycle("t1.idle");
    retire("t1.ret");
    check("t1.wdata_lit", out_wdata_o, 64'h0000_0000_BEEF_0000);
    cycle("t1.after");

    // Misaligned split pair
    push(32'h2003, 4'h8, 32'h1122_3344, 0, 0, 0, "t2.p0");
    push(32'h2004, 4'h7, 32'h5566_7788, 1, 0, 0, "t2.p1");
    check("t2.level2", 64'(level_o), 64'd2);
    retire("t2.ret");
    check("t2.cnt_lit", 64'(out_cnt_o), 64'd2);
    check("t2.addr_lit", out_addr_o, 64'h0000_2004_0000_2003);

    // Level 3, then retire + flush + push together
    for (int i = 0; i < 3; i++) push(32'h3000 + 32'(4*i), 4'hF, 32'hA0 + 32'(i), 1, 0, 0, "t6.fill");
    push(32'h3100, 4'hF, 32'hDEAD, 1, 1, 1, "t6.rfp");
    check("t6.empty_lit", 64'(empty_o), 64'd1);
    check("t6.err_lit", 64'(err_o), 64'd0);
    cycle("t6.after");

    // Fill, overflow, drain with pointer wrap
    for (int i = 0; i < DEPTH; i++) push(32'h4000 + 32'(4*i) + 32'(i), 4'h1, 32'hC0DE_0000 + 32'(i), 1, 0, 0, "t3.fill");
    push(32'h4FF0, 4'hF, 32'hFFFF_FFFF, 1, 0, 0, "t3.ovf");
    check("t3.err_lit", 64'(err_o), 64'd1);
    for (int i = 0; i < DEPTH; i++) retire("t3.drain");

    // Retire on empty
    retire("t4.empty_ret");

    // Push + retire at level 1
    push(32'h5000, 4'h3, 32'h0000_1234, 1, 0, 0, "t5.p0");
    push(32'h5001, 4'h6, 32'h0000_5678, 1, 1, 0, "t5.pr");
    retire("t5.ret2");

    // Mid-stream asynchronous reset with level 2 and a group on the outputs
    push(32'h6000, 4'hF, 32'h1, 1, 0, 0, "t7.p0");
    push(32'h6004, 4'hF, 32'h2, 1, 0, 0, "t7.p1");
    push(32'h6008, 4'hF, 32'h3, 1, 1, 0, "t7.pr");
    do_reset();
    cycle("t7.post");

    // Randomized traffic
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 399) == 0) begin
        do_reset();
      end else begin
        trans_valid_i = ($urandom_range(0, 99) < 55);
        trans_addr_i  = $urandom();
        trans_we_i    = 1'($urandom());
        trans_be_i    = 4'($urandom());
        trans_wdata_i = $urandom();
        trans_last_i  = ($urandom_range(0, 99) < 70);
        retire_i      = ($urandom_range(0, 99) < 45);
        flush_i       = ($urandom_range(0, 99) < 4);
        cycle("rnd");
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
